// File: rtl/sad_min_search.sv
// sad_min_search: block-matching SAD accumulator with a running minimum search.
// Ports: clk/rst, start pulse, cur_pix/ref_pix word stream qualified by only_read,
// ready/busy status, per-candidate sad_valid/cand_sad, running min_sad/best_mv_x/best_mv_y, done pulse.
module sad_min_search #(
  parameter int PAIRS = 128,
  parameter int SR_W  = 8,
  parameter int SR_H  = 8,
  parameter int MV_W  = 4,
  parameter int SAD_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      cur_pix,
  input  logic [15:0]      ref_pix,
  input  logic             only_read,
  output logic             ready,
  output logic             busy,
  output logic             sad_valid,
  output logic [SAD_W-1:0] cand_sad,
  output logic [SAD_W-1:0] min_sad,
  output logic [MV_W-1:0]  best_mv_x,
  output logic [MV_W-1:0]  best_mv_y,
  output logic             done
);

  localparam int WCW = $clog2(PAIRS);
  localparam int CXW = $clog2(SR_W);
  localparam int CYW = $clog2(SR_H);
  localparam logic [MV_W-1:0] HALF_X = MV_W'(SR_W / 2);
  localparam logic [MV_W-1:0] HALF_Y = MV_W'(SR_H / 2);

  typedef enum logic [1:0] {IDLE, ACC, CMP, DONE} state_t;

  state_t           state, state_nxt;
  logic [SAD_W-1:0] acc;
  logic [WCW-1:0]   word_cnt;
  logic [CXW-1:0]   cand_x;
  logic [CYW-1:0]   cand_y;

  function automatic logic [7:0] absdiff(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  logic             consume;
  logic             last_word;
  logic             last_cand;
  logic [8:0]       word_sad;
  logic [SAD_W-1:0] acc_sum;

  assign consume   = (state == ACC) && !only_read;
  assign last_word = (word_cnt == WCW'(PAIRS - 1));
  assign last_cand = (cand_x == CXW'(SR_W - 1)) && (cand_y == CYW'(SR_H - 1));
  assign word_sad  = {1'b0, absdiff(cur_pix[15:8], ref_pix[15:8])}
                   + {1'b0, absdiff(cur_pix[7:0],  ref_pix[7:0])};
  assign acc_sum   = acc + SAD_W'(word_sad);

  assign ready = (state == ACC);
  assign busy  = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = ACC;
      ACC:  if (consume && last_word) state_nxt = CMP;
      CMP:  state_nxt = last_cand ? DONE : ACC;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      word_cnt  <= '0;
      cand_x    <= '0;
      cand_y    <= '0;
      sad_valid <= 1'b0;
      cand_sad  <= '0;
      min_sad   <= '0;
      best_mv_x <= '0;
      best_mv_y <= '0;
      done      <= 1'b0;
    end else begin
      // Pulses are set on the cycle entering CMP/DONE so they are high during that state.
      sad_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            acc      <= '0;
            word_cnt <= '0;
            cand_x   <= '0;
            cand_y   <= '0;
            min_sad  <= '1;
          end
        end
        ACC: begin
          if (consume) begin
            acc      <= acc_sum;
            word_cnt <= word_cnt + WCW'(1);
            if (last_word) begin
              cand_sad  <= acc_sum;
              sad_valid <= 1'b1;
            end
          end
        end
        CMP: begin
          // Strict compare: on a tie the earlier candidate in raster order wins.
          if (acc < min_sad) begin
            min_sad   <= acc;
            best_mv_x <= MV_W'(cand_x) - HALF_X;
            best_mv_y <= MV_W'(cand_y) - HALF_Y;
          end
          acc      <= '0;
          word_cnt <= '0;
          if (cand_x == CXW'(SR_W - 1)) begin
            cand_x <= '0;
            cand_y <= cand_y + CYW'(1);
          end else begin
            cand_x <= cand_x + CXW'(1);
          end
          if (last_cand) done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sad_min_search.md
Name: sad_min_search

Overview:
- Block-matching SAD stage placed directly downstream of the current-pixel delay line.
- Consumes the delay line's 16-bit current-pixel word stream, which it has already aligned to the reference-pixel stream, plus the delay line's only_read stall flag.
- For each candidate position in the search window, accumulates the sum of absolute differences (SAD) over one block, then tracks the minimum SAD and its motion vector.
- Reports the best motion vector once the whole window has been scanned.

Parameters:
- PAIRS, 128: 16-bit words (2 pixels each) per block; 128 words = one 16x16 block.
- SR_W, 8: candidate columns in the search window.
- SR_H, 8: candidate rows in the search window.
- MV_W, 4: width of each signed motion-vector component.
- SAD_W, 16: accumulator and SAD output width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a window search; honoured only in IDLE.
- cur_pix  in  16  current-block pixels; [15:8] = pixel 0, [7:0] = pixel 1, unsigned.
- ref_pix  in  16  reference pixels, same packing.
- only_read  in  1  1 = no valid word this cycle (memory read-only / pipeline fill); 0 = valid word.
- ready  out  1  1 when in ACC; a word is consumed on cycles where ready=1 and only_read=0.
- busy  out  1  1 in any state other than IDLE.
- sad_valid  out  1  one-cycle pulse when a candidate SAD completes.
- cand_sad  out  SAD_W  SAD of the candidate just completed; valid with sad_valid.
- min_sad  out  SAD_W  running minimum SAD.
- best_mv_x  out  MV_W  signed x offset of the best candidate.
- best_mv_y  out  MV_W  signed y offset of the best candidate.
- done  out  1  one-cycle pulse when the window search is finished.

Behaviour:
- Reset (rst=1, asynchronous): state=IDLE. ready, busy, sad_valid, done = 0. cand_sad, min_sad, best_mv_x, best_mv_y = 0. All counters = 0.
- Reset asserted mid-search aborts the search; no done pulse is produced.
- States:
  - IDLE: on start, go to ACC. On that transition: accumulator=0, word_cnt=0, cand_x=0, cand_y=0, min_sad=all-ones.
  - start is ignored in every state except IDLE.
  - ACC: each cycle with only_read=0:
    - acc += |cur_pix[15:8]-ref_pix[15:8]| + |cur_pix[7:0]-ref_pix[7:0]|
    - each absolute difference is 8-bit; their sum is 9-bit, zero-extended to SAD_W.
    - word_cnt increments by 1.
    - the word with word_cnt=PAIRS-1 completes the candidate; next state = CMP.
  - ACC with only_read=1: acc and word_cnt hold; no consumption.
  - CMP (one cycle, ready=0):
    - sad_valid=1 and cand_sad=acc.
    - If acc < min_sad (strict): min_sad <= acc; best_mv_x <= cand_x - SR_W/2; best_mv_y <= cand_y - SR_H/2.
    - Equal SAD keeps the earlier candidate.
    - acc <= 0; word_cnt <= 0.
    - Advance raster order: cand_x increments; cand_x wraps at SR_W-1 to 0 and cand_y increments.
    - If the candidate was (SR_W-1, SR_H-1), go to DONE; otherwise go back to ACC.
  - DONE (one cycle): done=1, then IDLE.
  - Results hold in IDLE until the next start.
- Cycle cost per candidate: PAIRS cycles with only_read=0, plus 1 CMP cycle.
- Upstream must not present valid words during CMP and DONE (ready=0). Words presented then are dropped.
- Accumulator never overflows: PAIRS*510 = 65280 < 2^16 at the defaults.
- Motion-vector range at defaults: x and y each in -4..+3, two's complement.
- sad_valid and done are registered outputs, high for exactly one cycle.

Test Plan:
- Case 1, identical data: start; 64 candidates x 128 words with cur_pix=ref_pix=16'h8080 and only_read=0 -> 64 sad_valid pulses, each with cand_sad=0. min_sad=0; best_mv = (-4,-4), the first candidate, by tie rule. done 1 cycle after the last CMP.
- Case 2, planted minimum: cur=16'h0000. ref=16'h0101 for every candidate except candidate index 19 (x=3, y=2), where ref=16'h0000 -> cand_sad=256 for each non-target candidate and 0 for candidate 19. min_sad=0; best_mv=(-1,-2).
- Case 3, saturating differences: cur=16'hFF00, ref=16'h00FF -> each word adds 510; cand_sad=65280 with no wrap.
- Case 4, stalls: insert only_read=1 for 3 cycles every 10 words; include only_read=1 for the first 4 cycles after start -> SAD values identical to the no-stall run. ready stays high during stalls.
- Case 5, reset abort: assert rst during candidate 5 at word 60 -> all outputs 0 immediately, state IDLE, no done pulse. A new start then runs a full, correct search.
- Case 6, start while busy: pulse start during ACC and during CMP -> ignored; counters are not reset. A start pulsed on the DONE cycle is also ignored.
